// File: rtl/mips_core_pkg.sv
// Shared core types: ALU control codes and the ALU reservation-station entry.
package mips_core_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int CTL_W  = 5;

    typedef enum logic [CTL_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_NOR  = 5'd5,
        ALU_SLT  = 5'd6,
        ALU_SLTU = 5'd7,
        ALU_SLL  = 5'd8,
        ALU_SRL  = 5'd9,
        ALU_SRA  = 5'd10,
        ALU_LUI  = 5'd11,
        ALU_BEQ  = 5'd12,
        ALU_BNE  = 5'd13,
        ALU_BLEZ = 5'd14,
        ALU_BGTZ = 5'd15,
        ALU_BLTZ = 5'd16,
        ALU_BGEZ = 5'd17,
        ALU_MTC0 = 5'd18
    } AluCtl;

    typedef struct packed {
        logic              valid;
        AluCtl             ctl;
        logic [TAG_W-1:0]  tag;
        logic              op1_rdy;
        logic [DATA_W-1:0] op1;
        logic              op2_rdy;
        logic [DATA_W-1:0] op2;
    } alu_rs_entry_t;

endpackage

// File: rtl/oldest_ready_select.sv
// Picks the single oldest eligible entry using the age matrix.
module oldest_ready_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]            eligible,
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
    output logic [DEPTH-1:0]            grant,
    output logic                        any_grant
);

    // An entry wins when no other eligible entry is older than it.
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = eligible[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && eligible[j] && older[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
        any_grant = |eligible;
    end

endmodule

// File: rtl/alu_issue_scheduler.sv
// ALU reservation station: buffers dispatched ops, wakes operands off the CDB,
// issues the oldest fully-ready op into a registered issue slot.
module alu_issue_scheduler
    import mips_core_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = DATA_W,
    parameter int TAG_WIDTH  = TAG_W,
    parameter int CTL_WIDTH  = CTL_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [CTL_WIDTH-1:0]       disp_ctl,
    input  logic [TAG_WIDTH-1:0]       disp_tag,
    input  logic                       disp_op1_rdy,
    input  logic [DATA_WIDTH-1:0]      disp_op1,
    input  logic                       disp_op2_rdy,
    input  logic [DATA_WIDTH-1:0]      disp_op2,
    input  logic                       cdb_valid,
    input  logic [TAG_WIDTH-1:0]       cdb_tag,
    input  logic [DATA_WIDTH-1:0]      cdb_data,
    output logic                       iss_valid,
    input  logic                       iss_stall,
    output logic [CTL_WIDTH-1:0]       iss_ctl,
    output logic [TAG_WIDTH-1:0]       iss_tag,
    output logic [DATA_WIDTH-1:0]      iss_op1,
    output logic [DATA_WIDTH-1:0]      iss_op2,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    alu_rs_entry_t              ent_q [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] age_q;
    logic [DEPTH-1:0][DEPTH-1:0] age_d;
    logic [DEPTH-1:0]           valid_vec;
    logic [DEPTH-1:0]           elig;
    logic [DEPTH-1:0]           grant;
    logic                       any_grant;
    logic                       can_issue;
    logic                       issue_fire;
    logic                       disp_fire;
    logic [IW-1:0]              alloc_idx;
    alu_rs_entry_t              new_ent;
    alu_rs_entry_t              sel_ent;
    logic                       hit1;
    logic                       hit2;
    logic [CW-1:0]              occ;

    always_comb begin
        valid_vec = '0;
        elig      = '0;
        occ       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent_q[i].valid;
            elig[i]      = ent_q[i].valid & ent_q[i].op1_rdy & ent_q[i].op2_rdy;
            occ          = occ + CW'(ent_q[i].valid);
        end
    end

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                alloc_idx = IW'(i);
            end
        end
    end

    // Registered valid bits only: a slot freed by issue this edge is not reusable yet.
    assign disp_ready = !(&valid_vec) && !flush;
    assign disp_fire  = disp_valid && disp_ready;
    assign can_issue  = !(iss_valid && iss_stall);
    assign issue_fire = can_issue && any_grant;
    assign occupancy  = occ;

    oldest_ready_select #(
        .DEPTH (DEPTH)
    ) u_sel (
        .eligible  (elig),
        .older     (age_q),
        .grant     (grant),
        .any_grant (any_grant)
    );

    // Same-cycle CDB bypass so a dispatch never misses its wakeup.
    always_comb begin
        hit1            = cdb_valid && (cdb_tag == disp_op1[TAG_WIDTH-1:0]);
        hit2            = cdb_valid && (cdb_tag == disp_op2[TAG_WIDTH-1:0]);
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.ctl     = AluCtl'(disp_ctl);
        new_ent.tag     = disp_tag;
        new_ent.op1_rdy = disp_op1_rdy || hit1;
        new_ent.op1     = (!disp_op1_rdy && hit1) ? cdb_data : disp_op1;
        new_ent.op2_rdy = disp_op2_rdy || hit2;
        new_ent.op2     = (!disp_op2_rdy && hit2) ? cdb_data : disp_op2;
    end

    always_comb begin
        sel_ent = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel_ent = ent_q[i];
            end
        end
    end

    // Survivors become older than the newcomer; the issued entry drops out.
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_fire && grant[i]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    age_d[i][j] = 1'b0;
                    age_d[j][i] = 1'b0;
                end
            end
        end
        if (disp_fire) begin
            for (int j = 0; j < DEPTH; j++) begin
                age_d[alloc_idx][j] = 1'b0;
                age_d[j][alloc_idx] = valid_vec[j] && !(issue_fire && grant[j]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            age_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i].valid <= 1'b0;
            end
            age_q <= '0;
        end else begin
            age_q <= age_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (disp_fire && alloc_idx == IW'(i)) begin
                    ent_q[i] <= new_ent;
                end else if (issue_fire && grant[i]) begin
                    ent_q[i].valid <= 1'b0;
                end else if (ent_q[i].valid && cdb_valid) begin
                    if (!ent_q[i].op1_rdy &&
                        ent_q[i].op1[TAG_WIDTH-1:0] == cdb_tag) begin
                        ent_q[i].op1     <= cdb_data;
                        ent_q[i].op1_rdy <= 1'b1;
                    end
                    if (!ent_q[i].op2_rdy &&
                        ent_q[i].op2[TAG_WIDTH-1:0] == cdb_tag) begin
                        ent_q[i].op2     <= cdb_data;
                        ent_q[i].op2_rdy <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid <= 1'b0;
            iss_ctl   <= '0;
            iss_tag   <= '0;
            iss_op1   <= '0;
            iss_op2   <= '0;
        end else if (flush) begin
            iss_valid <= 1'b0;
        end else if (can_issue) begin
            iss_valid <= any_grant;
            if (any_grant) begin
                iss_ctl <= sel_ent.ctl;
                iss_tag <= sel_ent.tag;
                iss_op1 <= sel_ent.op1;
                iss_op2 <= sel_ent.op2;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Bench for alu_issue_scheduler: directed table, corner sequences,
// and random traffic against an age-ordered queue model.
module tb_alu_issue_scheduler;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [4:0]  disp_ctl;
    logic [4:0]  disp_tag;
    logic        disp_op1_rdy;
    logic [31:0] disp_op1;
    logic        disp_op2_rdy;
    logic [31:0] disp_op2;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        iss_valid;
    logic        iss_stall;
    logic [4:0]  iss_ctl;
    logic [4:0]  iss_tag;
    logic [31:0] iss_op1;
    logic [31:0] iss_op2;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_scheduler #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (32),
        .TAG_WIDTH  (5),
        .CTL_WIDTH  (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_ctl     (disp_ctl),
        .disp_tag     (disp_tag),
        .disp_op1_rdy (disp_op1_rdy),
        .disp_op1     (disp_op1),
        .disp_op2_rdy (disp_op2_rdy),
        .disp_op2     (disp_op2),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .iss_valid    (iss_valid),
        .iss_stall    (iss_stall),
        .iss_ctl      (iss_ctl),
        .iss_tag      (iss_tag),
        .iss_op1      (iss_op1),
        .iss_op2      (iss_op2),
        .occupancy    (occupancy)
    );

    // Reference model: queue kept in dispatch (age) order.
    typedef struct {
        logic [4:0]  ctl;
        logic [4:0]  tag;
        bit          r1;
        logic [31:0] o1;
        bit          r2;
        logic [31:0] o2;
    } m_ent_t;

    m_ent_t      mq[$];
    bit          m_iv;
    logic [4:0]  m_ctl;
    logic [4:0]  m_tag;
    logic [31:0] m_o1;
    logic [31:0] m_o2;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_iv  = 0;
        m_ctl = '0;
        m_tag = '0;
        m_o1  = '0;
        m_o2  = '0;
    endtask

    task automatic model_edge();
        bit     fire;
        int     idx;
        m_ent_t e;
        fire = disp_valid && (mq.size() < DEPTH) && !flush;
        if (flush) begin
            mq.delete();
            m_iv = 0;
            return;
        end
        if (!(m_iv && iss_stall)) begin
            idx = -1;
            for (int k = 0; k < mq.size(); k++) begin
                if (idx < 0 && mq[k].r1 && mq[k].r2) idx = k;
            end
            if (idx >= 0) begin
                m_iv  = 1;
                m_ctl = mq[idx].ctl;
                m_tag = mq[idx].tag;
                m_o1  = mq[idx].o1;
                m_o2  = mq[idx].o2;
                mq.delete(idx);
            end else begin
                m_iv = 0;
            end
        end
        if (cdb_valid) begin
            for (int k = 0; k < mq.size(); k++) begin
                if (!mq[k].r1 && mq[k].o1[4:0] == cdb_tag) begin
                    mq[k].r1 = 1;
                    mq[k].o1 = cdb_data;
                end
                if (!mq[k].r2 && mq[k].o2[4:0] == cdb_tag) begin
                    mq[k].r2 = 1;
                    mq[k].o2 = cdb_data;
                end
            end
        end
        if (fire) begin
            e.ctl = disp_ctl;
            e.tag = disp_tag;
            e.r1  = disp_op1_rdy;
            e.o1  = disp_op1;
            e.r2  = disp_op2_rdy;
            e.o2  = disp_op2;
            if (!e.r1 && cdb_valid && cdb_tag == e.o1[4:0]) begin
                e.r1 = 1;
                e.o1 = cdb_data;
            end
            if (!e.r2 && cdb_valid && cdb_tag == e.o2[4:0]) begin
                e.r2 = 1;
                e.o2 = cdb_data;
            end
            mq.push_back(e);
        end
    endtask

    // One clock: pre-edge handshake check, model update, post-edge check.
    task automatic step();
        #1;
        chk("m_disp_ready", disp_ready, (mq.size() < DEPTH) && !flush);
        chk("m_occ_pre", occupancy, mq.size());
        @(posedge clk);
        model_edge();
        #1;
        chk("m_iss_valid", iss_valid, m_iv);
        if (m_iv) begin
            chk("m_iss_ctl", iss_ctl, m_ctl);
            chk("m_iss_tag", iss_tag, m_tag);
            chk("m_iss_op1", iss_op1, m_o1);
            chk("m_iss_op2", iss_op2, m_o2);
        end
        chk("m_occ", occupancy, mq.size());
        @(negedge clk);
    endtask

    task automatic drive(input bit dv, input int ctl, input int tag,
                         input bit r1, input logic [31:0] o1,
                         input bit r2, input logic [31:0] o2,
                         input bit cv, input int ct, input logic [31:0] cd,
                         input bit st, input bit fl);
        disp_valid   = dv;
        disp_ctl     = 5'(ctl);
        disp_tag     = 5'(tag);
        disp_op1_rdy = r1;
        disp_op1     = o1;
        disp_op2_rdy = r2;
        disp_op2     = o2;
        cdb_valid    = cv;
        cdb_tag      = 5'(ct);
        cdb_data     = cd;
        iss_stall    = st;
        flush        = fl;
    endtask

    task automatic idle(input bit st);
        drive(0, 0, 0, 1, 0, 1, 0, 0, 31, 0, st, 0);
    endtask

    typedef struct {
        bit          dv;
        int          ctl;
        int          tag;
        bit          r1;
        logic [31:0] o1;
        bit          r2;
        logic [31:0] o2;
        bit          cv;
        int          ct;
        logic [31:0] cd;
        bit          eiv;
        int          etag;
        logic [31:0] eo1;
        logic [31:0] eo2;
        int          eocc;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1, 0, 3, 1, 5, 1, 7, 0, 31, 0, 0, 0, 0, 0, 1};
        tbl[1]  = '{0, 0, 0, 1, 0, 1, 0, 0, 31, 0, 1, 3, 5, 7, 0};
        tbl[2]  = '{0, 0, 0, 1, 0, 1, 0, 0, 31, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 1, 0, 9, 1, 2, 0, 31, 0, 0, 0, 0, 0, 1};
        tbl[4]  = '{1, 0, 2, 1, 3, 1, 4, 0, 31, 0, 0, 0, 0, 0, 2};
        tbl[5]  = '{0, 0, 0, 1, 0, 1, 0, 1, 9, 32'h10, 1, 2, 3, 4, 1};
        tbl[6]  = '{0, 0, 0, 1, 0, 1, 0, 0, 31, 0, 1, 1, 32'h10, 2, 0};
        tbl[7]  = '{0, 0, 0, 1, 0, 1, 0, 0, 31, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 2, 6, 0, 4, 1, 1, 1, 4, 32'hAB, 0, 0, 0, 0, 1};
        tbl[9]  = '{0, 0, 0, 1, 0, 1, 0, 0, 31, 0, 1, 6, 32'hAB, 1, 0};
        tbl[10] = '{0, 0, 0, 1, 0, 1, 0, 0, 31, 0, 0, 0, 0, 0, 0};

        rst_n = 1'b0;
        idle(0);
        model_reset();
        #1;
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_iss_tag", iss_tag, 0);
        chk("rst_iss_op1", iss_op1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].dv, tbl[i].ctl, tbl[i].tag, tbl[i].r1, tbl[i].o1,
                  tbl[i].r2, tbl[i].o2, tbl[i].cv, tbl[i].ct, tbl[i].cd, 0, 0);
            step();
            chk($sformatf("t%0d_iv", i), iss_valid, tbl[i].eiv);
            chk($sformatf("t%0d_occ", i), occupancy, tbl[i].eocc);
            if (tbl[i].eiv) begin
                chk($sformatf("t%0d_tag", i), iss_tag, tbl[i].etag);
                chk($sformatf("t%0d_op1", i), iss_op1, tbl[i].eo1);
                chk($sformatf("t%0d_op2", i), iss_op2, tbl[i].eo2);
            end
        end

        // Fill, stall, drain oldest-first
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 10 + k, 0, 20, 1, k, 0, 31, 0, 0, 0);
            step();
        end
        chk("fill_occ", occupancy, 4);
        drive(1, 0, 15, 1, 1, 1, 1, 1, 20, 32'h55, 0, 0);
        #1;
        chk("fill_rdy", disp_ready, 0);
        step();
        idle(1);
        step();
        chk("stall_t0", iss_tag, 10);
        chk("stall_o0", iss_op1, 32'h55);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("stall_hold_v", iss_valid, 1);
            chk("stall_hold_t", iss_tag, 10);
            chk("stall_occ", occupancy, 3);
        end
        idle(0);
        for (int k = 1; k < 4; k++) begin
            step();
            chk("drain_tag", iss_tag, 10 + k);
            chk("drain_op2", iss_op2, k);
        end
        step();
        chk("drain_done", iss_valid, 0);

        // Flush with 3 entries and a held issue
        drive(1, 3, 1, 1, 11, 1, 12, 0, 31, 0, 0, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1, 4, 2 + k, 0, 21, 1, 0, 0, 31, 0, 1, 0);
            step();
        end
        chk("pre_flush_occ", occupancy, 3);
        chk("pre_flush_iv", iss_valid, 1);
        drive(1, 0, 9, 1, 0, 1, 0, 0, 31, 0, 1, 1);
        #1;
        chk("flush_rdy", disp_ready, 0);
        step();
        chk("flush_occ", occupancy, 0);
        chk("flush_iv", iss_valid, 0);
        idle(0);
        #1;
        chk("post_flush_rdy", disp_ready, 1);
        step();

        // Async reset with full station mid-stall
        drive(1, 0, 7, 1, 70, 1, 71, 0, 31, 0, 0, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 20 + k, 0, 22, 1, k, 0, 31, 0, 1, 0);
            step();
        end
        chk("full_occ", occupancy, 4);
        chk("full_iv", iss_valid, 1);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_iv", iss_valid, 0);
        chk("arst_occ", occupancy, 0);
        chk("arst_tag", iss_tag, 0);
        chk("arst_op1", iss_op1, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 0, 1, 0, 1, 22, 32'h99, 0, 0);
        step();
        idle(0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("arst_quiet", iss_valid, 0);
        end

        // Random traffic against the queue model
        for (int n = 0; n < 800; n++) begin
            bit          r1;
            bit          r2;
            logic [31:0] o1;
            logic [31:0] o2;
            r1 = $urandom_range(0, 1) == 1;
            r2 = $urandom_range(0, 1) == 1;
            o1 = $urandom;
            o2 = $urandom;
            if (!r1) o1[4:0] = 5'($urandom_range(0, 7));
            if (!r2) o2[4:0] = 5'($urandom_range(0, 7));
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 18),
                  $urandom_range(0, 31), r1, o1, r2, o2,
                  $urandom_range(0, 9) < 4, $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
